// File: rtl/ex_mem_stage_pkg.sv
// Shared CPU definitions for the execute-to-memory pipeline stage:
// stage states, exception cause codes and a small overflow helper.
package ex_mem_stage_pkg;

    // The stage is either streaming results or parked on an exception.
    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } stage_state_e;

    // Exception cause codes; zero is reserved to mean "no exception".
    localparam logic [4:0] CAUSE_NONE     = 5'd0;
    localparam logic [4:0] CAUSE_OVERFLOW = 5'd12;

    // An ALU overflow only traps for signed instructions.
    function automatic logic isSignedOverflow(input logic overflow, input logic unsig);
        return overflow & ~unsig;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // Increment on each event unless the counter is already at its maximum.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ex_mem_stage.sv
// Execute-to-memory pipeline register with valid/ready handshakes.
// Signed ALU overflows are squashed and reported as an exception; the
// stage then refuses new work until the exception is acknowledged.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter logic [4:0] OV_CAUSE = ex_mem_stage_pkg::CAUSE_OVERFLOW,
    parameter int         CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_aluout,
    input  logic             in_overflow,
    input  logic             in_unsig,
    input  logic [4:0]       in_rd,
    input  logic             in_regwrite,
    input  logic             in_memread,
    input  logic             in_memwrite,
    input  logic [31:0]      in_store_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_aluout,
    output logic [31:0]      out_store_data,
    output logic [4:0]       out_rd,
    output logic             out_regwrite,
    output logic             out_memread,
    output logic             out_memwrite,
    output logic             exc_valid,
    output logic [31:0]      exc_epc,
    output logic [4:0]       exc_cause,
    input  logic             exc_ack,
    output logic [CNT_W-1:0] ovf_count
);

    stage_state_e state_q;

    logic        outValid_q, outValid_d;
    logic [31:0] outPc_q, outPc_d;
    logic [31:0] outAlu_q, outAlu_d;
    logic [31:0] outStore_q, outStore_d;
    logic [4:0]  outRd_q, outRd_d;
    logic        outRegWrite_q, outRegWrite_d;
    logic        outMemRead_q, outMemRead_d;
    logic        outMemWrite_q, outMemWrite_d;
    logic        excValid_q;
    logic [31:0] excEpc_q;
    logic [4:0]  excCause_q;

    logic accept;
    logic loadResult;
    logic enterTrap;

    assign in_ready   = (state_q == RUN) & (~outValid_q | out_ready);
    assign accept     = in_valid & in_ready;
    assign enterTrap  = accept & ~flush & isSignedOverflow(in_overflow, in_unsig);
    assign loadResult = accept & ~flush & ~isSignedOverflow(in_overflow, in_unsig);

    // Next value of the result register: flush wins, then a new result,
    // then draining; data fields only change when a new result loads.
    always_comb begin
        outValid_d    = outValid_q;
        outPc_d       = outPc_q;
        outAlu_d      = outAlu_q;
        outStore_d    = outStore_q;
        outRd_d       = outRd_q;
        outRegWrite_d = outRegWrite_q;
        outMemRead_d  = outMemRead_q;
        outMemWrite_d = outMemWrite_q;
        if (flush) begin
            outValid_d = 1'b0;
        end else if (loadResult) begin
            outValid_d    = 1'b1;
            outPc_d       = in_pc;
            outAlu_d      = in_aluout;
            outStore_d    = in_store_data;
            outRd_d       = in_rd;
            outRegWrite_d = in_regwrite;
            outMemRead_d  = in_memread;
            outMemWrite_d = in_memwrite;
        end else if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
        end
    end

    // Result register toward the memory stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            outValid_q    <= 1'b0;
            outPc_q       <= '0;
            outAlu_q      <= '0;
            outStore_q    <= '0;
            outRd_q       <= '0;
            outRegWrite_q <= 1'b0;
            outMemRead_q  <= 1'b0;
            outMemWrite_q <= 1'b0;
        end else begin
            outValid_q    <= outValid_d;
            outPc_q       <= outPc_d;
            outAlu_q      <= outAlu_d;
            outStore_q    <= outStore_d;
            outRd_q       <= outRd_d;
            outRegWrite_q <= outRegWrite_d;
            outMemRead_q  <= outMemRead_d;
            outMemWrite_q <= outMemWrite_d;
        end
    end

    // Exception FSM: a signed overflow parks the stage in TRAP with the
    // report held until acknowledged; flush never releases a trap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            excValid_q <= 1'b0;
            excEpc_q   <= '0;
            excCause_q <= CAUSE_NONE;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (enterTrap) begin
                        state_q    <= TRAP;
                        excValid_q <= 1'b1;
                        excEpc_q   <= in_pc;
                        excCause_q <= OV_CAUSE;
                    end
                end
                TRAP: begin
                    if (exc_ack) begin
                        state_q    <= RUN;
                        excValid_q <= 1'b0;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_ovf_counter (
        .clock  (clock),
        .reset_n(reset_n),
        .inc    (enterTrap),
        .count  (ovf_count)
    );

    assign out_valid      = outValid_q;
    assign out_pc         = outPc_q;
    assign out_aluout     = outAlu_q;
    assign out_store_data = outStore_q;
    assign out_rd         = outRd_q;
    assign out_regwrite   = outRegWrite_q;
    assign out_memread    = outMemRead_q;
    assign out_memwrite   = outMemWrite_q;
    assign exc_valid      = excValid_q;
    assign exc_epc        = excEpc_q;
    assign exc_cause      = excCause_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios followed by
// random traffic, all compared against a transaction-level model.
module tb_ex_mem_stage;

    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clock;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_aluout;
    logic             in_overflow;
    logic             in_unsig;
    logic [4:0]       in_rd;
    logic             in_regwrite;
    logic             in_memread;
    logic             in_memwrite;
    logic [31:0]      in_store_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_aluout;
    logic [31:0]      out_store_data;
    logic [4:0]       out_rd;
    logic             out_regwrite;
    logic             out_memread;
    logic             out_memwrite;
    logic             exc_valid;
    logic [31:0]      exc_epc;
    logic [4:0]       exc_cause;
    logic             exc_ack;
    logic [CNT_W-1:0] ovf_count;

    int nAsserts = 0;
    int nFails   = 0;

    // Reference model state, kept as whole transactions.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] store;
        logic [7:0]  ctrl;
    } result_t;

    bit          mTrapped;
    bit          mHasResult;
    result_t     mResult;
    logic [31:0] mEpc;
    int          mTraps;

    ex_mem_stage #(
        .OV_CAUSE(5'd12),
        .CNT_W   (CNT_W)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_aluout     (in_aluout),
        .in_overflow   (in_overflow),
        .in_unsig      (in_unsig),
        .in_rd         (in_rd),
        .in_regwrite   (in_regwrite),
        .in_memread    (in_memread),
        .in_memwrite   (in_memwrite),
        .in_store_data (in_store_data),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_aluout    (out_aluout),
        .out_store_data(out_store_data),
        .out_rd        (out_rd),
        .out_regwrite  (out_regwrite),
        .out_memread   (out_memread),
        .out_memwrite  (out_memwrite),
        .exc_valid     (exc_valid),
        .exc_epc       (exc_epc),
        .exc_cause     (exc_cause),
        .exc_ack       (exc_ack),
        .ovf_count     (ovf_count)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        mTrapped   = 0;
        mHasResult = 0;
        mResult    = '{pc: 32'h0, alu: 32'h0, store: 32'h0, ctrl: 8'h0};
        mEpc       = 32'h0;
        mTraps     = 0;
    endtask

    function automatic bit modelReady();
        return !mTrapped && (!mHasResult || out_ready);
    endfunction

    // One clock edge of the stage, described as transaction outcomes.
    task automatic modelEdge();
        bit taken;
        taken = in_valid && modelReady();
        if (mTrapped && exc_ack) mTrapped = 0;
        if (mHasResult && out_ready) mHasResult = 0;
        if (flush) begin
            mHasResult = 0;
        end else if (taken) begin
            if (in_overflow && !in_unsig) begin
                mTrapped = 1;
                mEpc     = in_pc;
                if (mTraps < CNT_MAX) mTraps++;
            end else begin
                mHasResult = 1;
                mResult = '{pc: in_pc, alu: in_aluout, store: in_store_data,
                            ctrl: {in_rd, in_regwrite, in_memread, in_memwrite}};
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".out_valid"}, 32'(out_valid), 32'(mHasResult));
        checkVal({tag, ".out_pc"}, out_pc, mResult.pc);
        checkVal({tag, ".out_aluout"}, out_aluout, mResult.alu);
        checkVal({tag, ".out_store"}, out_store_data, mResult.store);
        checkVal({tag, ".out_ctrl"}, 32'({out_rd, out_regwrite, out_memread, out_memwrite}),
                 32'(mResult.ctrl));
        checkVal({tag, ".exc_valid"}, 32'(exc_valid), 32'(mTrapped));
        if (mTrapped) begin
            checkVal({tag, ".exc_epc"}, exc_epc, mEpc);
            checkVal({tag, ".exc_cause"}, 32'(exc_cause), 32'd12);
        end
        checkVal({tag, ".ovf_count"}, 32'(ovf_count), 32'(mTraps));
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic applyStimulus(input string tag);
        #1;
        checkVal({tag, ".in_ready"}, 32'(in_ready), 32'(modelReady()));
        @(posedge clock);
        modelEdge();
        #1;
        checkOutput(tag);
        @(negedge clock);
    endtask

    task automatic setIdle();
        in_valid      = 1'b0;
        in_pc         = 32'h0;
        in_aluout     = 32'h0;
        in_overflow   = 1'b0;
        in_unsig      = 1'b0;
        in_rd         = 5'd0;
        in_regwrite   = 1'b0;
        in_memread    = 1'b0;
        in_memwrite   = 1'b0;
        in_store_data = 32'h0;
        flush         = 1'b0;
        out_ready     = 1'b1;
        exc_ack       = 1'b0;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] alu,
                           input logic ovf, input logic unsig);
        in_valid      = 1'b1;
        in_pc         = pc;
        in_aluout     = alu;
        in_overflow   = ovf;
        in_unsig      = unsig;
        in_rd         = pc[6:2];
        in_regwrite   = 1'b1;
        in_memread    = pc[3];
        in_memwrite   = pc[4];
        in_store_data = ~alu;
    endtask

    // Directed scenarios first, then random traffic against the model.
    initial begin
        resetModel();
        setIdle();
        reset_n = 1'b0;
        #3;
        checkVal("reset.in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // Pass-through of a normal result.
        present(32'h100, 32'h5, 1'b0, 1'b0);
        applyStimulus("pass");
        checkVal("pass.aluout_const", out_aluout, 32'h5);
        checkVal("pass.pc_const", out_pc, 32'h100);

        // Backpressure: A loads, B stalls behind it, then both move.
        setIdle();
        applyStimulus("drain");
        out_ready = 1'b0;
        present(32'h140, 32'hA, 1'b0, 1'b0);
        applyStimulus("bpA");
        present(32'h144, 32'hB, 1'b0, 1'b0);
        applyStimulus("bpHold1");
        applyStimulus("bpHold2");
        checkVal("bp.held_alu", out_aluout, 32'hA);
        out_ready = 1'b1;
        applyStimulus("bpRelease");
        checkVal("bp.second_alu", out_aluout, 32'hB);
        setIdle();
        applyStimulus("bpIdle");

        // Signed overflow traps; stage stalls until acknowledged.
        present(32'h200, 32'h8000_0000, 1'b1, 1'b0);
        applyStimulus("ovf");
        checkVal("ovf.epc_const", exc_epc, 32'h200);
        checkVal("ovf.count_const", 32'(ovf_count), 32'd1);
        present(32'h204, 32'h1, 1'b0, 1'b0);
        applyStimulus("ovfStall");
        exc_ack = 1'b1;
        in_valid = 1'b0;
        applyStimulus("ovfAck");
        setIdle();

        // Unsigned overflow passes through uncounted.
        present(32'h200, 32'h8000_0000, 1'b1, 1'b1);
        applyStimulus("unsig");
        checkVal("unsig.alu_const", out_aluout, 32'h8000_0000);
        setIdle();
        applyStimulus("unsigIdle");

        // Flush beats a same-cycle trap; flush does not end a trap.
        present(32'h300, 32'h7FFF_FFFF, 1'b1, 1'b0);
        flush = 1'b1;
        applyStimulus("flushBeatsTrap");
        setIdle();
        present(32'h304, 32'h8000_0001, 1'b1, 1'b0);
        applyStimulus("trapAgain");
        setIdle();
        flush = 1'b1;
        applyStimulus("flushInTrap");
        exc_ack = 1'b1;
        applyStimulus("flushWithAck");
        setIdle();

        // Saturation: keep trapping until the counter is pinned.
        for (int i = 0; i < 5; i++) begin
            present(32'h400 + 32'(i * 4), 32'h8000_0000, 1'b1, 1'b0);
            applyStimulus("satTrap");
            setIdle();
            exc_ack = 1'b1;
            applyStimulus("satAck");
            setIdle();
        end
        checkVal("sat.count_const", 32'(ovf_count), 32'd3);

        // Reset asserted while trapped clears everything at once.
        present(32'h500, 32'h8000_0000, 1'b1, 1'b0);
        applyStimulus("preReset");
        setIdle();
        #2;
        reset_n = 1'b0;
        #1;
        resetModel();
        checkVal("asyncReset.exc_valid", 32'(exc_valid), 32'd0);
        checkVal("asyncReset.ovf_count", 32'(ovf_count), 32'd0);
        checkOutput("asyncReset");
        @(negedge clock);
        reset_n = 1'b1;
        present(32'h600, 32'h1234, 1'b0, 1'b0);
        applyStimulus("postReset");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid      = 1'($urandom_range(0, 3) != 0);
            in_pc         = $urandom;
            in_aluout     = $urandom;
            in_overflow   = 1'($urandom_range(0, 4) == 0);
            in_unsig      = 1'($urandom_range(0, 1));
            in_rd         = 5'($urandom);
            in_regwrite   = 1'($urandom_range(0, 1));
            in_memread    = 1'($urandom_range(0, 1));
            in_memwrite   = 1'($urandom_range(0, 1));
            in_store_data = $urandom;
            flush         = 1'($urandom_range(0, 15) == 0);
            out_ready     = 1'($urandom_range(0, 3) != 0);
            exc_ack       = 1'($urandom_range(0, 2) == 0);
            applyStimulus("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter OV_CAUSE, default 5'd12, is the exception cause code reported for signed arithmetic overflow.
REQ-002 Parameter CNT_W, default 8, is the width of the saturating overflow event counter.
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  execute stage presents an instruction.
REQ-006 in_ready  out  1  this stage accepts the instruction this cycle.
REQ-007 in_pc  in  32  PC of the presented instruction.
REQ-008 in_aluout  in  32  ALU result.
REQ-009 in_overflow  in  1  ALU overflow flag.
REQ-010 in_unsig  in  1  instruction is unsigned; overflow is ignored.
REQ-011 in_rd  in  5  destination register; in_regwrite, in_memread, in_memwrite  in  1 each  control bits.
REQ-012 in_store_data  in  32  store operand.
REQ-013 flush  in  1  squash the held and presented instructions.
REQ-014 out_valid  out  1, out_ready  in  1  downstream handshake toward the memory stage.
REQ-015 out_pc, out_aluout, out_store_data  out  32; out_rd  out  5; out_regwrite, out_memread, out_memwrite  out  1  registered copies.
REQ-016 exc_valid  out  1, exc_epc  out  32, exc_cause  out  5, exc_ack  in  1  exception report and acknowledge.
REQ-017 ovf_count  out  CNT_W  saturating count of trapped overflows.

Function
REQ-018 A transfer in SHALL occur when in_valid & in_ready; a transfer out SHALL occur when out_valid & out_ready.
REQ-019 in_ready SHALL be (state==RUN) & (~out_valid | out_ready), combinationally, with no dependence on in_valid.
REQ-020 On an accepted instruction with ~(in_overflow & ~in_unsig), all out_* fields SHALL load the in_* values and out_valid SHALL be 1 on the next cycle; latency is 1 cycle.
REQ-021 While out_valid & ~out_ready, every out_* field SHALL hold its value.
REQ-022 On a transfer out with no accepted instruction, out_valid SHALL go to 0 and the data fields SHALL hold their values.
REQ-023 An accepted instruction with in_overflow & ~in_unsig SHALL NOT set out_valid; the instruction is squashed.
REQ-024 In that case the stage SHALL instead load exc_epc=in_pc and exc_cause=OV_CAUSE, set exc_valid=1, and move RUN->TRAP.
REQ-025 In TRAP, in_ready SHALL be 0, and exc_valid, exc_epc and exc_cause SHALL hold until exc_ack is sampled high.
REQ-026 When exc_ack is sampled high in TRAP, the stage SHALL clear exc_valid and return to RUN; exc_ack in RUN SHALL be ignored.
REQ-027 The held out_valid entry SHALL still drain normally while the stage is in TRAP.
REQ-028 An overflow with in_unsig=1 SHALL be passed through as a normal result and SHALL NOT be counted.
REQ-029 ovf_count SHALL increment on each RUN->TRAP transition and saturate at 2^CNT_W-1.
REQ-030 flush SHALL clear out_valid on the next edge and SHALL discard any same-cycle accepted instruction, including an overflowing one (flush beats trap).
REQ-031 flush SHALL NOT clear a pending TRAP; only exc_ack exits TRAP.
REQ-032 A flush concurrent with exc_ack SHALL return the stage to RUN with out_valid=0.
REQ-033 States SHALL be RUN and TRAP only.

Reset
REQ-034 While reset_n=0, the stage SHALL be in RUN, and out_valid, exc_valid, ovf_count, all out_* data fields, exc_epc and exc_cause SHALL be 0, independent of clock.
REQ-035 Reset deassertion mid-operation SHALL leave no residual exception, and the first edge after deassertion SHALL accept normally.

Structure
REQ-036 The state enumeration and the cause codes (OV_CAUSE=12, reserved 0=none) SHALL live in the shared CPU package.
REQ-037 The saturating counter SHALL be the sub-module sat_counter (parameter width, inputs inc and reset_n); all other logic SHALL be flat.

Verification
REQ-038 Pass-through: pc=0x100, aluout=0x0000_0005, overflow=0, out_ready=1 -> next cycle out_valid=1, out_aluout=0x5, out_pc=0x100.
REQ-039 Backpressure: 2 accepted instructions with out_ready=0 -> first held stable, in_ready=0; out_ready=1 -> first drains, second accepted next cycle.
REQ-040 Signed overflow: aluout=0x8000_0000, overflow=1, unsig=0, pc=0x200 -> out_valid stays 0, exc_valid=1, exc_epc=0x200, exc_cause=12, ovf_count=1, in_ready=0 until exc_ack.
REQ-041 Unsigned overflow: same stimulus with unsig=1 -> normal output 0x8000_0000, exc_valid=0, ovf_count unchanged.
REQ-042 Flush vs. trap: overflowing instruction accepted with flush=1 -> no trap, out_valid=0; flush during TRAP -> exc_valid remains 1.
REQ-043 Saturation and reset: with CNT_W=2, 5 trap/ack cycles -> ovf_count=3; assert reset_n=0 mid-TRAP -> exc_valid=0, ovf_count=0 immediately.
